pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Single-clock startup and supervision sequencer for the iCE40 `SB_PLL40_CORE`. It drives the PLL's RESETB and BYPASS pins and watches its asynchronous LOCK output. A PLL that fails to lock in time is retried a bounded number of times. `o_ready` is asserted only after LOCK has been stable for a set period, and logic clocked from the PLL output is gated on it. The block sits in `top` beside the PLL instance and runs from the board reference clock.

## Interface
- `RESET_CYCLES`, 16: cycles `o_pll_resetb` is held low per attempt (≥2).
- `LOCK_TIMEOUT`, 4096: cycles allowed in WAIT for lock before the attempt fails (≥1, ≤2^24).
- `LOCK_STABLE`, 256: consecutive synchronized-lock-high cycles required before RUN (≥1, ≤2^24).
- `MAX_RETRIES`, 3: failed attempts tolerated before FAIL (1..15).

Ports:
- `i_clock`  in  1: board reference clock (same net as PLL REFERENCECLK).
- `i_reset`  in  1: synchronous, active-high reset.
- `i_pll_lock`  in  1: PLL LOCK, asynchronous to `i_clock`.
- `i_restart`  in  1: synchronous request to restart the sequence; 1-cycle pulse or level.
- `o_pll_resetb`  out  1: to PLL RESETB (active low).
- `o_pll_bypass`  out  1: to PLL BYPASS.
- `o_ready`  out  1: PLL clock usable.
- `o_fail`  out  1: retries exhausted.
- `o_lost_lock`  out  1: 1-cycle pulse on lock loss in RUN.
- `o_retries`  out  4: failed attempts since last reset/restart/RUN.
- `o_state`  out  3: HOLD=0, WAIT=1, STABLE=2, RUN=3, FAIL=4, BYPASS=5.

## Operation
- `i_pll_lock` passes through a 2-flop synchronizer, producing `lock_s`. Both flops reset to 0. Only `lock_s` is used.
- All outputs except `o_lost_lock` are Moore decodes of the registered state. `o_lost_lock` is a registered pulse.
- A single down-counter is shared across states and reloaded on every state entry.
- **HOLD**: `resetb`=0, `bypass`=0. Lasts exactly RESET_CYCLES cycles, then goes to WAIT.
- **WAIT**: `resetb`=1.
  - `lock_s`=1 → STABLE.
  - After LOCK_TIMEOUT cycles with `lock_s`=0, the attempt fails.
- **STABLE**: `resetb`=1.
  - After LOCK_STABLE consecutive cycles of `lock_s`=1 → RUN.
  - Any `lock_s`=0 → the attempt fails.
- **Attempt failure**: `o_retries` increments.
  - If the new value equals MAX_RETRIES → FAIL, or BYPASS when enabled.
  - Otherwise → HOLD.
- **RUN**: `resetb`=1, `o_ready`=1.
  - `lock_s`=0 → HOLD, `o_retries` cleared to 0, `o_lost_lock` pulses for the first HOLD cycle.
- **FAIL**: `resetb`=0, `bypass`=0, `o_ready`=0, `o_fail`=1. Lock is ignored. Exit only via `i_reset` or `i_restart`.
- **Restart**: `i_restart`=1 in any state → HOLD next cycle, `o_retries`=0. A level hold keeps the block in HOLD with the counter reloaded.
- **Priority**: `i_reset` > `i_restart` > timeout/lock events.
- **Reset values**: state HOLD, `o_pll_resetb`=0, `o_pll_bypass`=0, `o_ready`=0, `o_fail`=0, `o_lost_lock`=0, `o_retries`=0, synchronizer=00.

## Timing
- After the first edge with `i_reset`=0, `o_pll_resetb` stays 0 for exactly RESET_CYCLES cycles.
- `lock_s` lags `i_pll_lock` by 2 cycles.
- With lock already settled high: `o_ready` rises RESET_CYCLES+1+LOCK_STABLE cycles after reset release.
- Lock drop in RUN: `o_ready` falls 3 cycles after `i_pll_lock` falls (2-cycle sync + state register).
- Timeout path: one failed attempt lasts RESET_CYCLES+LOCK_TIMEOUT cycles.
- `o_retries` saturates at MAX_RETRIES and never wraps.
- Counters are sized from the parameters; no counter overflows.

## Configuration
- `PLL_BYPASS_FALLBACK_EN` defined: on exhaustion the state goes to BYPASS instead of FAIL.
  - BYPASS outputs: `resetb`=1, `bypass`=1, `o_ready`=1, `o_fail`=1. The PLL output then carries the reference clock, so downstream logic runs at the degraded rate.
  - Exit only via `i_reset` or `i_restart`.
- Undefined: BYPASS state absent, FAIL as specified, `o_pll_bypass` tied 0.

## Test plan
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE=8, MAX_RETRIES=2.
- **Nominal lock**: lock held 1 → `resetb` 0 for 4 cycles; `o_ready`=1 at cycle 13 after reset release; `o_state`=3; `o_fail`=0.
- **Lock never asserts**: lock held 0 → two attempts of 20 cycles each; `o_retries` reads 1 then 2; `o_state`=4; `o_fail`=1; `o_pll_resetb`=0; `o_ready`=0.
- **Fallback build**: same stimulus with `PLL_BYPASS_FALLBACK_EN` → `o_state`=5, `bypass`=1, `resetb`=1, `o_ready`=1, `o_fail`=1 at cycle 40.
- **Glitch in STABLE**: lock drops for 1 cycle mid-STABLE → `o_retries`=1, state returns to HOLD; lock then held → RUN.
- **Loss in RUN**: lock falls → `o_ready`=0 three cycles later; `o_lost_lock` is a single-cycle pulse; `o_retries`=0; the sequence re-runs to RUN.
- **Restart priority**: `i_restart` and a WAIT timeout in the same cycle → HOLD with `o_retries`=0. `i_reset` asserted in RUN → all outputs take their reset values next edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Startup/supervision sequencer for an iCE40 PLL: drives RESETB/BYPASS, qualifies LOCK, retries failed locks.
// Define PLL_BYPASS_FALLBACK_EN to fall back to PLL bypass instead of FAIL once retries are exhausted.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_pll_lock,
    input  logic       i_restart,
    output logic       o_pll_resetb,
    output logic       o_pll_bypass,
    output logic       o_ready,
    output logic       o_fail,
    output logic       o_lost_lock,
    output logic [3:0] o_retries,
    output logic [2:0] o_state
);

    localparam int unsigned MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
`ifdef PLL_BYPASS_FALLBACK_EN
        ,
        ST_BYPASS = 3'd5
`endif
    } state_t;

`ifdef PLL_BYPASS_FALLBACK_EN
    localparam state_t ST_EXHAUSTED = ST_BYPASS;
`else
    localparam state_t ST_EXHAUSTED = ST_FAIL;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       retries_nxt;
    logic             lost_nxt;
    logic             attempt_fail;
    logic [1:0]       lock_sync;
    logic             lock_s;

    assign lock_s  = lock_sync[1];
    assign o_state = state;

    // Next-state logic; a single down-counter is reloaded on every state entry.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        retries_nxt  = o_retries;
        lost_nxt     = 1'b0;
        attempt_fail = 1'b0;

        if (i_restart) begin
            state_nxt   = ST_HOLD;
            cnt_nxt     = HOLD_LOAD;
            retries_nxt = 4'd0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        cnt_nxt   = STABLE_LOAD;
                    end else if (cnt == '0) begin
                        attempt_fail = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        attempt_fail = 1'b1;
                    end else if (cnt == '0) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt   = ST_HOLD;
                        cnt_nxt     = HOLD_LOAD;
                        retries_nxt = 4'd0;
                        lost_nxt    = 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_nxt = state;
                end
`ifdef PLL_BYPASS_FALLBACK_EN
                ST_BYPASS: begin
                    state_nxt = state;
                end
`endif
                default: begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            endcase

            // Retry count stops at the limit because the exhausted state is terminal.
            if (attempt_fail) begin
                retries_nxt = o_retries + 4'd1;
                if (retries_nxt == RETRY_LIMIT) begin
                    state_nxt = ST_EXHAUSTED;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
        end
    end

    // State, synchronizer and registered Moore outputs decoded from the next state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lock_sync    <= 2'b00;
            state        <= ST_HOLD;
            cnt          <= HOLD_LOAD;
            o_retries    <= 4'd0;
            o_lost_lock  <= 1'b0;
            o_pll_resetb <= 1'b0;
            o_pll_bypass <= 1'b0;
            o_ready      <= 1'b0;
            o_fail       <= 1'b0;
        end else begin
            lock_sync    <= {lock_sync[0], i_pll_lock};
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            o_retries    <= retries_nxt;
            o_lost_lock  <= lost_nxt;
            o_pll_resetb <= !((state_nxt == ST_HOLD) || (state_nxt == ST_FAIL));
`ifdef PLL_BYPASS_FALLBACK_EN
            o_pll_bypass <= (state_nxt == ST_BYPASS);
            o_ready      <= (state_nxt == ST_RUN) || (state_nxt == ST_BYPASS);
            o_fail       <= (state_nxt == ST_FAIL) || (state_nxt == ST_BYPASS);
`else
            o_pll_bypass <= 1'b0;
            o_ready      <= (state_nxt == ST_RUN);
            o_fail       <= (state_nxt == ST_FAIL);
`endif
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RESET_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE=8, MAX_RETRIES=2.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       restart;
    logic       resetb;
    logic       bypass;
    logic       ready;
    logic       fail;
    logic       lost;
    logic [3:0] retries;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RESET_CYCLES(4),
        .LOCK_TIMEOUT(16),
        .LOCK_STABLE (8),
        .MAX_RETRIES (2)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_pll_lock  (lock),
        .i_restart   (restart),
        .o_pll_resetb(resetb),
        .o_pll_bypass(bypass),
        .o_ready     (ready),
        .o_fail      (fail),
        .o_lost_lock (lost),
        .o_retries   (retries),
        .o_state     (state)
    );

    typedef struct {
        int unsigned ticks;
        logic        lock;
        logic        restart;
        logic        resetb;
        logic        bypass;
        logic        ready;
        logic        fail;
        logic [2:0]  state;
        logic [3:0]  retries;
    } vec_t;

    vec_t vecs[16];

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_row(input int idx, input int unsigned t, input logic lk, input logic rs,
                           input logic rb, input logic bp, input logic rd, input logic fl,
                           input logic [2:0] st, input logic [3:0] rt);
        vecs[idx] = '{t, lk, rs, rb, bp, rd, fl, st, rt};
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            lock    = vecs[i].lock;
            restart = vecs[i].restart;
            tick(vecs[i].ticks);
            check($sformatf("row%0d.state", i),   int'(state),   int'(vecs[i].state));
            check($sformatf("row%0d.retries", i), int'(retries), int'(vecs[i].retries));
            check($sformatf("row%0d.resetb", i),  int'(resetb),  int'(vecs[i].resetb));
            check($sformatf("row%0d.bypass", i),  int'(bypass),  int'(vecs[i].bypass));
            check($sformatf("row%0d.ready", i),   int'(ready),   int'(vecs[i].ready));
            check($sformatf("row%0d.fail", i),    int'(fail),    int'(vecs[i].fail));
            check($sformatf("row%0d.lost", i),    int'(lost),    0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal lock: cycle 0 is the last edge with reset high.
        set_row(0,  0, 1, 0, 0, 0, 0, 0, 3'd0, 4'd0);
        set_row(1,  3, 1, 0, 0, 0, 0, 0, 3'd0, 4'd0);
        set_row(2,  1, 1, 0, 1, 0, 0, 0, 3'd1, 4'd0);
        set_row(3,  1, 1, 0, 1, 0, 0, 0, 3'd2, 4'd0);
        set_row(4,  7, 1, 0, 1, 0, 0, 0, 3'd2, 4'd0);
        set_row(5,  1, 1, 0, 1, 0, 1, 0, 3'd3, 4'd0);
        // Restart with lock never asserting: two 20-cycle attempts, then exhaustion.
        set_row(6,  1, 0, 1, 0, 0, 0, 0, 3'd0, 4'd0);
        set_row(7, 19, 0, 0, 1, 0, 0, 0, 3'd1, 4'd0);
        set_row(8,  1, 0, 0, 0, 0, 0, 0, 3'd0, 4'd1);
        set_row(9, 19, 0, 0, 1, 0, 0, 0, 3'd1, 4'd1);
`ifdef PLL_BYPASS_FALLBACK_EN
        set_row(10, 1, 0, 0, 1, 1, 1, 1, 3'd5, 4'd2);
        set_row(11, 6, 1, 0, 1, 1, 1, 1, 3'd5, 4'd2);
`else
        set_row(10, 1, 0, 0, 0, 0, 0, 1, 3'd4, 4'd2);
        set_row(11, 6, 1, 0, 0, 0, 0, 1, 3'd4, 4'd2);
`endif
        // Restart out of exhaustion, then restart coinciding with the second WAIT timeout.
        set_row(12,  1, 0, 1, 0, 0, 0, 0, 3'd0, 4'd0);
        set_row(13, 20, 0, 0, 0, 0, 0, 0, 3'd0, 4'd1);
        set_row(14, 19, 0, 0, 1, 0, 0, 0, 3'd1, 4'd1);
        set_row(15,  1, 0, 1, 0, 0, 0, 0, 3'd0, 4'd0);

        rst = 1'b1;
        lock = 1'b1;
        restart = 1'b0;
        tick(3);
        rst = 1'b0;
        check("reset.lost", int'(lost), 0);
        run_rows(0, 5);

        // Lock loss in RUN: ready drops 3 cycles later with a single lost_lock pulse.
        lock = 1'b0;
        tick(1);
        check("loss.c14.ready", int'(ready), 1);
        tick(1);
        check("loss.c15.ready", int'(ready), 1);
        check("loss.c15.lost", int'(lost), 0);
        tick(1);
        check("loss.c16.ready", int'(ready), 0);
        check("loss.c16.state", int'(state), 0);
        check("loss.c16.lost", int'(lost), 1);
        check("loss.c16.retries", int'(retries), 0);
        check("loss.c16.resetb", int'(resetb), 0);
        lock = 1'b1;
        tick(1);
        check("loss.c17.lost", int'(lost), 0);
        tick(11);
        check("loss.c28.state", int'(state), 2);
        tick(1);
        check("loss.c29.state", int'(state), 3);
        check("loss.c29.ready", int'(ready), 1);

        run_rows(6, 15);

        // One-cycle lock glitch in the middle of STABLE.
        restart = 1'b0;
        lock = 1'b1;
        tick(5);
        check("glitch.stable", int'(state), 2);
        tick(2);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        tick(1);
        check("glitch.still_stable", int'(state), 2);
        tick(1);
        check("glitch.hold", int'(state), 0);
        check("glitch.retries", int'(retries), 1);
        check("glitch.resetb", int'(resetb), 0);
        tick(12);
        check("glitch.restable", int'(state), 2);
        tick(1);
        check("glitch.run", int'(state), 3);
        check("glitch.ready", int'(ready), 1);

        // Reset taken from RUN.
        rst = 1'b1;
        tick(1);
        check("rst.state", int'(state), 0);
        check("rst.resetb", int'(resetb), 0);
        check("rst.bypass", int'(bypass), 0);
        check("rst.ready", int'(ready), 0);
        check("rst.fail", int'(fail), 0);
        check("rst.lost", int'(lost), 0);
        check("rst.retries", int'(retries), 0);
        rst = 1'b0;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
